// File: rtl/seq_shift_right_pkg.sv
// Shared types and helpers for the multi-cycle right shifter.
package seq_shift_pkg;

  // Default operand/result width of the shifter.
  localparam int DEFAULT_WIDTH = 32;

  // Sequencer states: accept a request, walk the shift stages, present the result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Number of log-step stages needed to cover every shift amount below width.
  function automatic int calc_log2w(input int width);
    int n;
    n = 0;
    while ((1 << n) < width) n++;
    return n;
  endfunction

endpackage

// File: rtl/seq_shift_right_stage.sv
// One combinational log-step stage: shifts right by 2^k when enabled,
// filling the vacated MSBs with the supplied fill bit.
module shift_right_stage #(
  parameter int WIDTH = 32,
  parameter int LOG2W = 5
) (
  input  logic [WIDTH-1:0] data,
  input  logic [LOG2W-1:0] k,
  input  logic             en,
  input  logic             fill,
  output logic [WIDTH-1:0] result
);

  logic [LOG2W-1:0] shamt;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] fill_mask;

  // Shift by the stage weight and merge fill bits into the vacated positions.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    result    = data;
    shamt     = LOG2W'(1) << k;
    shifted   = data >> shamt;
    fill_mask = ~({WIDTH{1'b1}} >> shamt);
    if (en) begin
      result = shifted | ({WIDTH{fill}} & fill_mask);
    end
  end

endmodule

// File: rtl/seq_shift_right.sv
// Multi-cycle logical/arithmetic right shifter. One shift-amount bit is
// consumed per clock through a single shared stage, so latency does not
// depend on the operand or the shift amount.
module seq_shift_right
  import seq_shift_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int LOG2W = calc_log2w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             arith,
  input  logic [WIDTH-1:0] A,
  input  logic [31:0]      B,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  // Counter value at which all stages have been applied.
  localparam logic [LOG2W:0] LAST_K = (LOG2W+1)'(LOG2W);

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [LOG2W-1:0] amt;
  logic [LOG2W:0]   k;
  logic             sign;
  logic             ovf;
  logic [WIDTH-1:0] out_q;

  logic [WIDTH-1:0] stage_out;
  logic             stage_en;
  logic             ovf_in;

  // Any set bit above the in-range field means the whole operand shifts out.
  assign ovf_in = |B[31:LOG2W];

  // An overflowing request still walks every stage, but never shifts.
  assign stage_en = ~ovf & amt[k[LOG2W-1:0]];

  shift_right_stage #(
    .WIDTH (WIDTH),
    .LOG2W (LOG2W)
  ) u_stage (
    .data   (work),
    .k      (k[LOG2W-1:0]),
    .en     (stage_en),
    .fill   (sign),
    .result (stage_out)
  );

  // Sequencer and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state <= IDLE;
      work  <= '0;
      amt   <= '0;
      k     <= '0;
      sign  <= 1'b0;
      ovf   <= 1'b0;
      out_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work  <= A;
            amt   <= B[LOG2W-1:0];
            sign  <= arith & A[WIDTH-1];
            ovf   <= ovf_in;
            k     <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (k == LAST_K) begin
            out_q <= ovf ? {WIDTH{sign}} : work;
            state <= DONE;
          end else begin
            work <= stage_out;
            k    <= k + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign done  = (state == DONE);
  assign out   = out_q;

endmodule

// File: tb/tb_seq_shift_right.sv
// Self-checking bench for seq_shift_right (WIDTH=32): fixed vectors, sweeps,
// random operations against a reference model, handshake and reset corners.
module tb_seq_shift_right;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        arith;
  logic [31:0] A;
  logic [31:0] B;
  logic        ready;
  logic        done;
  logic [31:0] out;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ar;
    logic [31:0] exp;
  } vec_t;

  seq_shift_right dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .arith (arith),
    .A     (A),
    .B     (B),
    .ready (ready),
    .done  (done),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: shift semantics from plain arithmetic.
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] b,
                                            input logic ar);
    logic [31:0] r;
    if (b >= 32) r = (ar && a[31]) ? 32'hFFFF_FFFF : 32'h0;
    else if (ar) r = $signed(a) >>> b;
    else         r = a >> b;
    return r;
  endfunction

  // One operation: start before E0, expect done right after E6 and ready after E7.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic ar,
                        input logic [31:0] exp, input string name);
    int n;
    logic [31:0] res;
    n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, " ready before start"}, {31'd0, ready}, 32'd1);
    start = 1'b1; A = a; B = b; arith = ar;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom; arith = 1'($urandom);
    n = 0;
    while (n < 20) begin
      if (n > 0 && done) break;
      @(negedge clk);
      n++;
      if (done) break;
    end
    check({name, " done edge"}, n, 32'd6);
    check({name, " out"}, out, exp);
    res = out;
    @(negedge clk);
    check({name, " done single pulse"}, {31'd0, done}, 32'd0);
    check({name, " ready after E7"}, {31'd0, ready}, 32'd1);
    check({name, " out held"}, out, res);
  endtask

  vec_t vecs[$];

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; arith = 1'b0; A = '0; B = '0;

    // Spec boundary vectors with hand-derived results.
    vecs.push_back('{32'h8000_0002, 32'd0,          1'b0, 32'h8000_0002});
    vecs.push_back('{32'h8000_0002, 32'd1,          1'b0, 32'h4000_0001});
    vecs.push_back('{32'h8000_0002, 32'd31,         1'b0, 32'h0000_0001});
    vecs.push_back('{32'h8000_0002, 32'd32,         1'b0, 32'h0000_0000});
    vecs.push_back('{32'h8000_0002, 32'd33,         1'b0, 32'h0000_0000});
    vecs.push_back('{32'h8000_0002, 32'd1,          1'b1, 32'hC000_0001});
    vecs.push_back('{32'h8000_0002, 32'd4,          1'b1, 32'hF800_0000});
    vecs.push_back('{32'h8000_0002, 32'd31,         1'b1, 32'hFFFF_FFFF});
    vecs.push_back('{32'h8000_0002, 32'd32,         1'b1, 32'hFFFF_FFFF});
    vecs.push_back('{32'h8000_0002, 32'hFFFF_FFFF,  1'b1, 32'hFFFF_FFFF});
    vecs.push_back('{32'h8000_0002, 32'hFFFF_FFFF,  1'b0, 32'h0000_0000});
    vecs.push_back('{32'h7FFF_FFFF, 32'd40,         1'b1, 32'h0000_0000});
    vecs.push_back('{32'hF000_0000, 32'd4,          1'b1, 32'hFF00_0000});

    // Reset and idle behaviour.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle ready", {31'd0, ready}, 32'd1);
      check("idle done",  {31'd0, done},  32'd0);
      check("idle out",   out,            32'd0);
    end

    // Table vectors.
    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].ar, vecs[i].exp, $sformatf("vec%0d", i));

    // SRL and SRA sweeps over B=0..33.
    for (int s = 0; s < 2; s++)
      for (int b = 0; b < 34; b++)
        run_op(32'h8000_0002, 32'(b), 1'(s), ref_shift(32'h8000_0002, 32'(b), 1'(s)),
               $sformatf("sweep ar=%0d b=%0d", s, b));

    // Random operations, biased to cover both in-range and huge shift amounts.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      logic        rr;
      ra = $urandom;
      rb = (i % 3 == 0) ? $urandom : 32'($urandom_range(0, 35));
      rr = 1'($urandom);
      run_op(ra, rb, rr, ref_shift(ra, rb, rr), $sformatf("rand%0d", i));
    end

    // Handshake: start held high, A changes every cycle.
    begin
      logic [31:0] pend[$];
      logic [31:0] held;
      logic [31:0] exp_r;
      bit          have_held;
      int          n_acc, n_done, last_acc;
      have_held = 0; n_acc = 0; n_done = 0; last_acc = -1;
      @(negedge clk);
      for (int c = 0; c < 70; c++) begin
        if (done) begin
          n_done++;
          exp_r = (pend.size() > 0) ? pend.pop_front() : 32'hDEAD_BEEF;
          check("hs result", out, exp_r);
          held = out; have_held = 1;
        end else if (have_held) begin
          check("hs out held", out, held);
        end
        start = (c < 60); arith = 1'b1; B = 32'd3; A = $urandom;
        if (ready && start) begin
          // Next acceptance after done at E6, idle after E7, sampled at E8.
          if (last_acc >= 0) check("hs accept gap", 32'(c - last_acc), 32'd8);
          last_acc = c;
          pend.push_back(ref_shift(A, 32'd3, 1'b1));
          n_acc++;
        end
        @(negedge clk);
      end
      start = 1'b0;
      check("hs done count", 32'(n_done), 32'(n_acc));
    end

    // Reset in the middle of an operation.
    while (!ready) @(negedge clk);
    start = 1'b1; A = 32'hF000_0000; B = 32'd4; arith = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort out",   out,            32'd0);
    check("abort ready", {31'd0, ready}, 32'd1);
    check("abort done",  {31'd0, done},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int dcount;
      dcount = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (done) dcount++;
      end
      check("abort no done", 32'(dcount), 32'd0);
    end
    run_op(32'hF000_0000, 32'd4, 1'b1, 32'hFF00_0000, "after abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
